// File: rtl/matvec_mac_engine_pkg.sv
// mac_pkg: shared sizes and state type for the
// systolic matrix-vector MAC engine.
package mac_pkg;

    localparam int N      = 8;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mac_state_t;

endpackage

// File: rtl/matvec_mac_engine_mac_unit.sv
// mac_unit: one unsigned multiply-accumulate cell
// with synchronous clear and enable.
module mac_unit #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    // full-width product, zero-extended into the accumulator
    always_comb begin
        prod  = PW'(a) * PW'(b);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/matvec_mac_engine.sv
// matvec_mac_engine: drains N skewed A-row FIFOs and the
// b FIFO through a chain of MACs to form C = A*b.
module matvec_mac_engine #(
    parameter int N      = mac_pkg::N,
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [N-1:0][DATA_W-1:0]    a_q,
    input  logic [N-1:0]                a_full,
    input  logic [N-1:0]                a_empty,
    output logic [N-1:0]                a_rden,
    input  logic [DATA_W-1:0]           b_q,
    input  logic                        b_full,
    input  logic                        b_empty,
    output logic                        b_rden,
    output logic [N-1:0][ACC_W-1:0]     result,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    import mac_pkg::*;

    localparam int TW = $clog2(2 * N);

    mac_state_t                 state_q;
    mac_state_t                 state_d;
    logic [TW-1:0]              t_q;
    logic [TW-1:0]              t_d;
    logic                       clr;
    logic [N-1:0]               en_q;
    logic [N-2:0][DATA_W-1:0]   b_pipe_q;
    logic [N-1:0][DATA_W-1:0]   b_mac;
    logic                       err_q;
    logic                       err_d;

    // FSM next state, cycle counter and skewed read decode
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        clr     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        b_rden  = 1'b0;
        a_rden  = '0;
        unique case (state_q)
            IDLE: begin
                if (start && (&a_full) && b_full) begin
                    state_d = RUN;
                    t_d     = '0;
                    clr     = 1'b1;
                end
            end
            RUN: begin
                busy   = 1'b1;
                b_rden = (int'(t_q) < N);
                for (int i = 0; i < N; i++) begin
                    a_rden[i] = (int'(t_q) >= i) &&
                                (int'(t_q) < i + N);
                end
                t_d = t_q + 1'b1;
                if (t_q == TW'(2 * N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // sticky flag for a read issued against an empty FIFO
    always_comb begin
        err_d = err_q | (b_rden & b_empty) | (|(a_rden & a_empty));
    end

    // state, counter, MAC enables, b delay line and err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            t_q      <= '0;
            en_q     <= '0;
            b_pipe_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            en_q     <= a_rden;
            b_pipe_q <= {b_pipe_q[N-3:0], b_q};
            err_q    <= err_d;
        end
    end

    assign b_mac = {b_pipe_q, b_q};
    assign err   = err_q;

    for (genvar g = 0; g < N; g++) begin : g_mac
        mac_unit #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_mac (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (en_q[g]),
            .a     (a_q[g]),
            .b     (b_mac[g]),
            .acc   (result[g])
        );
    end

endmodule

// File: tb/tb_matvec_mac_engine.sv
// tb_matvec_mac_engine: FIFO models plus a plain
// dot-product reference for the MAC engine.
module tb_matvec_mac_engine;

    localparam int NN = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [NN-1:0][7:0]   a_q = '0;
    logic [NN-1:0]        a_full;
    logic [NN-1:0]        a_empty;
    logic [NN-1:0]        a_rden;
    logic [7:0]           b_q = '0;
    logic                 b_full;
    logic                 b_empty;
    logic                 b_rden;
    logic [NN-1:0][23:0]  result;
    logic                 busy;
    logic                 done;
    logic                 err;

    always #5 clk = ~clk;

    matvec_mac_engine dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_q     (a_q),
        .a_full  (a_full),
        .a_empty (a_empty),
        .a_rden  (a_rden),
        .b_q     (b_q),
        .b_full  (b_full),
        .b_empty (b_empty),
        .b_rden  (b_rden),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    logic [7:0]  amem [NN][NN];
    logic [7:0]  bmem [NN];
    logic [7:0]  a_stage [NN][NN];
    logic [7:0]  b_stage [NN];
    int          a_cnt [NN];
    int          a_rp [NN];
    int          b_cnt;
    int          b_rp;
    logic        fill_a = 1'b0;
    logic        fill_b = 1'b0;
    logic        mon_clr = 1'b0;
    logic [NN-1:0] a_empty_frc = '0;
    int          cyc;
    int          rd_n [NN+1];
    int          rd_first [NN+1];
    int          rd_last [NN+1];
    int          busy_n;
    int          exp_c [NN];
    int          n_chk;
    int          n_fail;

    always_comb begin
        for (int i = 0; i < NN; i++) begin
            a_full[i]  = (a_cnt[i] == NN);
            a_empty[i] = (a_cnt[i] == 0) || a_empty_frc[i];
        end
        b_full  = (b_cnt == NN);
        b_empty = (b_cnt == 0);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NN; i++) begin
            if (a_rden[i] && a_cnt[i] > 0) begin
                a_q[i]   <= amem[i][a_rp[i]];
                a_rp[i]  <= a_rp[i] + 1;
                a_cnt[i] <= a_cnt[i] - 1;
            end
            if (fill_a) begin
                for (int j = 0; j < NN; j++) amem[i][j] <= a_stage[i][j];
                a_rp[i]  <= 0;
                a_cnt[i] <= NN;
            end
        end
        if (b_rden && b_cnt > 0) begin
            b_q   <= bmem[b_rp];
            b_rp  <= b_rp + 1;
            b_cnt <= b_cnt - 1;
        end
        if (fill_b) begin
            for (int j = 0; j < NN; j++) bmem[j] <= b_stage[j];
            b_rp  <= 0;
            b_cnt <= NN;
        end
        for (int i = 0; i <= NN; i++) begin
            if (mon_clr) begin
                rd_n[i] <= 0;
            end else if ((i < NN) ? a_rden[i] : b_rden) begin
                if (rd_n[i] == 0) rd_first[i] <= cyc;
                rd_last[i] <= cyc;
                rd_n[i]    <= rd_n[i] + 1;
            end
        end
        if (mon_clr) busy_n <= 0;
        else if (busy) busy_n <= busy_n + 1;
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input bit do_a, input bit do_b);
        @(negedge clk);
        fill_a = do_a;
        fill_b = do_b;
        @(negedge clk);
        fill_a = 1'b0;
        fill_b = 1'b0;
    endtask

    task automatic clear_mon();
        @(negedge clk);
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic compute_ref();
        for (int i = 0; i < NN; i++) begin
            exp_c[i] = 0;
            for (int j = 0; j < NN; j++)
                exp_c[i] += int'(a_stage[i][j]) * int'(b_stage[j]);
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < NN; i++) begin
            for (int j = 0; j < NN; j++) a_stage[i][j] = 8'($urandom);
            b_stage[i] = 8'($urandom);
        end
    endtask

    // start is already high; wait for accept, then check the job
    task automatic finish_job(input string tag);
        int k;
        int c1;
        int cd;
        k = 0;
        while (!busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_accept"}, 32'(busy), 1);
        c1 = cyc;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 32'(done), 1);
        cd = cyc;
        chk({tag, "_done_lat"}, 32'(cd - c1), 16);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 16);
        for (int i = 0; i < NN; i++)
            chk($sformatf("%s_C%0d", tag, i), 32'(result[i]),
                32'(exp_c[i]));
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
        for (int i = 0; i <= NN; i++) begin
            int off;
            off = (i < NN) ? i : 0;
            chk($sformatf("%s_nrd%0d", tag, i), 32'(rd_n[i]), 8);
            chk($sformatf("%s_first%0d", tag, i),
                32'(rd_first[i] - c1), 32'(off));
            chk($sformatf("%s_last%0d", tag, i),
                32'(rd_last[i] - c1), 32'(off + 7));
        end
    endtask

    task automatic run_job(input string tag);
        compute_ref();
        fill(1'b1, 1'b1);
        clear_mon();
        start = 1'b1;
        finish_job(tag);
    endtask

    initial begin
        int k;
        int c1;
        n_chk  = 0;
        n_fail = 0;
        repeat (3) @(negedge clk);
        chk("rst_a_rden", 32'(a_rden), 0);
        chk("rst_b_rden", 32'(b_rden), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_result", 32'(|result), 0);
        rst_n = 1'b1;

        for (int i = 0; i < NN; i++) begin
            for (int j = 0; j < NN; j++) a_stage[i][j] = 8'd1;
            b_stage[i] = 8'(i + 1);
        end
        run_job("ones");
        chk("ones_C0_36", 32'(result[0]), 36);
        chk("ones_err", 32'(err), 0);

        begin
            int pi_v [NN] = '{3, 1, 4, 1, 5, 9, 2, 6};
            for (int i = 0; i < NN; i++) begin
                for (int j = 0; j < NN; j++)
                    a_stage[i][j] = (i == j) ? 8'd1 : 8'd0;
                b_stage[i] = 8'(pi_v[i]);
            end
            run_job("ident");
            for (int i = 0; i < NN; i++)
                chk($sformatf("ident_pi%0d", i), 32'(result[i]),
                    32'(pi_v[i]));
        end

        for (int i = 0; i < NN; i++) begin
            for (int j = 0; j < NN; j++) a_stage[i][j] = 8'd255;
            b_stage[i] = 8'd255;
        end
        run_job("max");
        chk("max_C7", 32'(result[7]), 32'h7F008);

        for (int r = 0; r < 3; r++) begin
            set_random();
            run_job($sformatf("rand%0d", r));
        end

        set_random();
        compute_ref();
        fill(1'b1, 1'b0);
        clear_mon();
        start = 1'b1;
        repeat (10) @(negedge clk);
        chk("nob_busy", 32'(busy), 0);
        chk("nob_rd_a", 32'(rd_n[0] + rd_n[7]), 0);
        chk("nob_rd_b", 32'(rd_n[NN]), 0);
        fill(1'b0, 1'b1);
        @(negedge clk);
        chk("nob_accept_next", 32'(busy), 1);
        finish_job("nob");

        set_random();
        compute_ref();
        fill(1'b1, 1'b1);
        clear_mon();
        start = 1'b1;
        k = 0;
        while (!busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("rstmid_accept", 32'(busy), 1);
        c1 = cyc;
        repeat (5) @(negedge clk);
        chk("rstmid_cycle", 32'(cyc - c1), 5);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_a_rden", 32'(a_rden), 0);
        chk("rstmid_b_rden", 32'(b_rden), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_result", 32'(|result), 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_random();
        run_job("after_rst");

        set_random();
        a_empty_frc = 8'b0000_1000;
        run_job("err");
        a_empty_frc = '0;
        chk("err_set", 32'(err), 1);
        start = 1'b1;
        repeat (5) @(negedge clk);
        chk("err_no_restart", 32'(busy), 0);
        chk("err_no_extra_rd3", 32'(rd_n[3]), 8);
        chk("err_no_extra_rdb", 32'(rd_n[NN]), 8);
        start = 1'b0;
        set_random();
        run_job("err2");
        chk("err_sticky", 32'(err), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("err_rst_clear", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
